// File: rtl/processors_control_multi.sv
// Pass sequencer for a bank of NUM_PROC processor lanes.
// Clear, stream columns, unload results; stall, lane masking, errors.
module processors_control_multi #(
  parameter  int N_WIDTH  = 4,
  parameter  int NUM_PROC = 4,
  localparam int SEL_W    = $clog2(NUM_PROC)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N_WIDTH-1:0]  N,
  input  logic                stall,
  output logic [NUM_PROC-1:0] proc_enable,
  output logic                proc_clear,
  output logic [N_WIDTH-1:0]  col_idx,
  output logic [N_WIDTH-1:0]  row_base,
  output logic                out_valid,
  output logic [SEL_W-1:0]    out_sel,
  output logic [N_WIDTH-1:0]  out_row,
  output logic                busy,
  output logic                done,
  output logic                err_zero
);

  localparam int W1 = N_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_WIDTH-1:0]  n_q, n_d;
  logic [N_WIDTH-1:0]  rb_q, rb_d;
  logic [N_WIDTH-1:0]  col_q, col_d;
  logic [SEL_W-1:0]    lane_q, lane_d;
  logic [NUM_PROC-1:0] en_q, en_d;
  logic                clear_q, clear_d;
  logic                valid_q, valid_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_WIDTH-1:0]  row_q, row_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [NUM_PROC-1:0] mask_d;
  logic                last_lane;
  logic                last_pass;

  // Lane activity for the upcoming pass; widened so row sums never wrap.
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      mask_d[i] = ({1'b0, rb_d} + W1'(i)) < {1'b0, n_q};
    end
  end

  // End-of-lane and end-of-job detection for the unload phase.
  always_comb begin
    last_lane = (lane_q == SEL_W'(NUM_PROC - 1)) ||
      (({1'b0, rb_q} + W1'(lane_q) + W1'(1)) >= {1'b0, n_q});
    last_pass = ({1'b0, rb_q} + W1'(NUM_PROC)) >= {1'b0, n_q};
  end

  // Next-state, counter updates and next registered outputs.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    rb_d    = rb_q;
    col_d   = col_q;
    lane_d  = lane_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (N != '0) begin
            n_d     = N;
            rb_d    = '0;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        col_d   = '0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (!stall) begin
          if (col_q == n_q - N_WIDTH'(1)) begin
            col_d   = '0;
            lane_d  = '0;
            state_d = S_OUTPUT;
          end else begin
            col_d = col_q + N_WIDTH'(1);
          end
        end
      end
      S_OUTPUT: begin
        if (!stall) begin
          if (last_lane) begin
            lane_d = '0;
            if (last_pass) begin
              state_d = S_DONE;
            end else begin
              rb_d    = rb_q + N_WIDTH'(NUM_PROC);
              state_d = S_CLEAR;
            end
          end else begin
            lane_d = lane_q + SEL_W'(1);
          end
        end
      end
      S_DONE: begin
        rb_d    = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    clear_d = (state_d == S_CLEAR);
    valid_d = (state_d == S_OUTPUT);
    done_d  = (state_d == S_DONE);
    en_d    = '0;
    if (state_d == S_COMPUTE &&
        !(state_q == S_COMPUTE && stall)) begin
      en_d = mask_d;
    end
    sel_d = valid_d ? lane_d : '0;
    row_d = valid_d ? (rb_d + N_WIDTH'(lane_d)) : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      rb_q    <= '0;
      col_q   <= '0;
      lane_q  <= '0;
      en_q    <= '0;
      clear_q <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      rb_q    <= rb_d;
      col_q   <= col_d;
      lane_q  <= lane_d;
      en_q    <= en_d;
      clear_q <= clear_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign proc_enable = en_q;
  assign proc_clear  = clear_q;
  assign col_idx     = col_q;
  assign row_base    = rb_q;
  assign out_valid   = valid_q;
  assign out_sel     = sel_q;
  assign out_row     = row_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_zero    = err_q;

endmodule
